pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter AWIDTH, default 5: register-address width.
REQ-002 Parameter CNT_WIDTH, default 16: width of the performance counters.
REQ-003 Parameter BR_IN_EX, default 1: branch resolves in EX (1) or in MEM (0).
REQ-004 p_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 p_rst  in  1  asynchronous, active-low reset.
REQ-006 p_i_ce  in  1  pipeline advance enable.
REQ-007 i_opcode  in  `OPCODE_WIDTH (6)  opcode of the instruction in ID.
REQ-008 i_rs, i_rt, i_rd  in  AWIDTH each  register fields of the instruction in ID.
REQ-009 i_branch_taken  in  1  branch outcome from the datapath, valid in the resolving stage.
REQ-010 o_pc_we, o_ifid_we, o_ifid_flush  out  1 each  fetch-side controls.
REQ-011 o_ex_RegDst, o_ex_ALUSrc  out  1 each  EX-stage controls.
REQ-012 o_mem_MemRead, o_mem_MemWrite, o_mem_Branch  out  1 each  MEM-stage controls.
REQ-013 o_wb_RegWrite, o_wb_MemtoReg  out  1 each; o_wb_dst  out  AWIDTH  write-back controls and destination.
REQ-014 o_fwd_a, o_fwd_b  out  2 each  ALU operand forward selects.
REQ-015 o_stall_cnt, o_flush_cnt  out  CNT_WIDTH each  performance counters.

Function
REQ-016 Decode is combinational from i_opcode: R-type 000000 -> RegDst, RegWrite. lw 100011 -> ALUSrc, MemRead, MemtoReg, RegWrite. sw 101011 -> ALUSrc, MemWrite. beq 000100 -> Branch. addi 001000 -> ALUSrc, RegWrite. Any other opcode -> all-zero bundle (NOP).
REQ-017 Destination: i_rd when RegDst=1, otherwise i_rt.
REQ-018 Pipeline registers ID/EX, EX/MEM and MEM/WB carry the control bundle and destination; ID/EX also carries rs and rt; one stage per clock when p_i_ce=1.
REQ-019 Load-use stall: EX MemRead=1, EX dst!=0, and EX dst equals i_rs or i_rt -> o_pc_we=0, o_ifid_we=0, ID/EX loads a bubble (all-zero controls, dst 0); EX/MEM and MEM/WB advance.
REQ-020 Flush when i_branch_taken=1 and the resolving-stage Branch=1 (EX if BR_IN_EX=1, else MEM): o_ifid_flush=1, ID/EX loads a bubble; with BR_IN_EX=0, EX/MEM also loads a bubble.
REQ-021 Flush has priority over stall in the same cycle; that cycle counts as a flush only, and o_pc_we=1.
REQ-022 o_fwd_a = 2'b10 if MEM RegWrite=1, MEM dst!=0 and MEM dst==EX rs; else 2'b01 if the same condition holds for WB; else 2'b00. o_fwd_b is the same using EX rt. MEM takes priority over WB.
REQ-023 Register 0 never causes a stall or a forward.
REQ-024 p_i_ce=0: all registers and counters hold, o_pc_we=0, o_ifid_we=0, o_ifid_flush=0.
REQ-025 Counters increment by 1 per stall or flush cycle with p_i_ce=1, and saturate at all-ones (no wrap).
REQ-026 All stage outputs come directly from the pipeline registers (zero-latency views); o_pc_we, o_ifid_we, o_ifid_flush and the forward selects are combinational.

Reset
REQ-027 p_rst=0 asynchronously clears all pipeline registers and counters. Stage outputs are 0, o_fwd_* = 00, o_pc_we=1, o_ifid_we=1, o_ifid_flush=0.
REQ-028 Reset asserted mid-stall or mid-flush aborts it; the first edge after release behaves as an empty pipeline.

Structure
REQ-029 Opcode constants, `OPCODE_WIDTH and the control-bundle field layout live in the shared definitions header already used by the controller.
REQ-030 Decode is one sub-module, ctrl_decode (purely combinational); hazard, forward and counter logic live in pipe_hazard_ctrl.

Verification
REQ-031 Reset, then a lw with rt=5 followed by an add with rs=5 -> exactly one cycle with o_pc_we=0, o_ifid_we=0 and a bubble in EX; o_stall_cnt=1.
REQ-032 add to $3, then add with rs=3 -> o_fwd_a=10 with no stall; a third add with rt=3 one cycle later -> o_fwd_b=01.
REQ-033 beq with i_branch_taken=1, BR_IN_EX=1 -> o_ifid_flush=1 for one cycle, ID/EX bubble, o_flush_cnt=1; repeat with BR_IN_EX=0 -> EX/MEM bubble as well.
REQ-034 Stall condition and taken branch in the same cycle -> flush only: o_pc_we=1, o_stall_cnt unchanged.
REQ-035 CNT_WIDTH=2 with 5 consecutive stalls -> o_stall_cnt=3; p_i_ce=0 for 3 cycles -> all outputs frozen and o_pc_we=0.
REQ-036 lw targeting $0 followed by a use of $0 -> no stall; o_fwd_a=00.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline controller: opcodes, the
// control bundle layout grouped by consuming stage, and forward selects.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned OPCODE_WIDTH = 6;

   localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'b101011;
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'b001000;

   typedef struct packed {
      logic reg_dst;
      logic alu_src;
   } ex_ctrl_t;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic branch;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } ctrl_t;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_t;

endpackage

// File: rtl/pipe_hazard_ctrl_decode.sv
// Combinational opcode decode into the control bundle; unknown opcodes
// decode to an all-zero bundle (NOP).
module ctrl_decode
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [OPCODE_WIDTH-1:0] opcode,
   output ctrl_t                   ctrl
);

   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.ex.reg_dst   = 1'b1;
            ctrl.wb.reg_write = 1'b1;
         end
         OP_LW: begin
            ctrl.ex.alu_src    = 1'b1;
            ctrl.mem.mem_read  = 1'b1;
            ctrl.wb.mem_to_reg = 1'b1;
            ctrl.wb.reg_write  = 1'b1;
         end
         OP_SW: begin
            ctrl.ex.alu_src    = 1'b1;
            ctrl.mem.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl.mem.branch = 1'b1;
         end
         OP_ADDI: begin
            ctrl.ex.alu_src   = 1'b1;
            ctrl.wb.reg_write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: ID/EX, EX/MEM, MEM/WB control registers, load-use stall,
// branch flush, operand forwarding and saturating stall/flush counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned AWIDTH    = 5,
   parameter int unsigned CNT_WIDTH = 16,
   parameter bit          BR_IN_EX  = 1'b1
) (
   input  logic                    p_clk,
   input  logic                    p_rst,
   input  logic                    p_i_ce,
   input  logic [OPCODE_WIDTH-1:0] i_opcode,
   input  logic [AWIDTH-1:0]       i_rs,
   input  logic [AWIDTH-1:0]       i_rt,
   input  logic [AWIDTH-1:0]       i_rd,
   input  logic                    i_branch_taken,
   output logic                    o_pc_we,
   output logic                    o_ifid_we,
   output logic                    o_ifid_flush,
   output logic                    o_ex_RegDst,
   output logic                    o_ex_ALUSrc,
   output logic                    o_mem_MemRead,
   output logic                    o_mem_MemWrite,
   output logic                    o_mem_Branch,
   output logic                    o_wb_RegWrite,
   output logic                    o_wb_MemtoReg,
   output logic [AWIDTH-1:0]       o_wb_dst,
   output logic [1:0]              o_fwd_a,
   output logic [1:0]              o_fwd_b,
   output logic [CNT_WIDTH-1:0]    o_stall_cnt,
   output logic [CNT_WIDTH-1:0]    o_flush_cnt
);

   ctrl_t                id_ctrl;
   ctrl_t                idex_ctrl;
   logic [AWIDTH-1:0]    id_dst, idex_dst, idex_rs, idex_rt;
   mem_ctrl_t            exmem_mem;
   wb_ctrl_t             exmem_wb, memwb_wb;
   logic [AWIDTH-1:0]    exmem_dst, memwb_dst;
   logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;
   logic                 load_use, flush, stall;
   fwd_sel_t             fwd_a, fwd_b;

   ctrl_decode u_decode (
      .opcode (i_opcode),
      .ctrl   (id_ctrl)
   );

   assign id_dst = id_ctrl.ex.reg_dst ? i_rd : i_rt;

   assign load_use = idex_ctrl.mem.mem_read && (idex_dst != '0) &&
                     ((idex_dst == i_rs) || (idex_dst == i_rt));
   assign flush    = i_branch_taken &&
                     (BR_IN_EX ? idex_ctrl.mem.branch : exmem_mem.branch);
   // A taken branch discards the stalled instruction, so flush wins outright.
   assign stall    = load_use && !flush;

   assign o_pc_we      = p_i_ce && !stall;
   assign o_ifid_we    = p_i_ce && !stall;
   assign o_ifid_flush = p_i_ce && flush;

   function automatic fwd_sel_t fwd_pick(
      input logic [AWIDTH-1:0] src,
      input logic              mem_rw,
      input logic [AWIDTH-1:0] mem_dst,
      input logic              wb_rw,
      input logic [AWIDTH-1:0] wb_dst
   );
      if (mem_rw && (mem_dst != '0) && (mem_dst == src)) return FWD_MEM;
      if (wb_rw && (wb_dst != '0) && (wb_dst == src))    return FWD_WB;
      return FWD_NONE;
   endfunction

   assign fwd_a = fwd_pick(idex_rs, exmem_wb.reg_write, exmem_dst,
                           memwb_wb.reg_write, memwb_dst);
   assign fwd_b = fwd_pick(idex_rt, exmem_wb.reg_write, exmem_dst,
                           memwb_wb.reg_write, memwb_dst);

   always_ff @(posedge p_clk or negedge p_rst) begin
      if (!p_rst) begin
         idex_ctrl <= '0;
         idex_dst  <= '0;
         idex_rs   <= '0;
         idex_rt   <= '0;
         exmem_mem <= '0;
         exmem_wb  <= '0;
         exmem_dst <= '0;
         memwb_wb  <= '0;
         memwb_dst <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (p_i_ce) begin
         if (flush || stall) begin
            idex_ctrl <= '0;
            idex_dst  <= '0;
            idex_rs   <= '0;
            idex_rt   <= '0;
         end else begin
            idex_ctrl <= id_ctrl;
            idex_dst  <= id_dst;
            idex_rs   <= i_rs;
            idex_rt   <= i_rt;
         end
         if (flush && !BR_IN_EX) begin
            exmem_mem <= '0;
            exmem_wb  <= '0;
            exmem_dst <= '0;
         end else begin
            exmem_mem <= idex_ctrl.mem;
            exmem_wb  <= idex_ctrl.wb;
            exmem_dst <= idex_dst;
         end
         memwb_wb  <= exmem_wb;
         memwb_dst <= exmem_dst;
         if (flush) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
         end else if (stall) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

   assign o_ex_RegDst    = idex_ctrl.ex.reg_dst;
   assign o_ex_ALUSrc    = idex_ctrl.ex.alu_src;
   assign o_mem_MemRead  = exmem_mem.mem_read;
   assign o_mem_MemWrite = exmem_mem.mem_write;
   assign o_mem_Branch   = exmem_mem.branch;
   assign o_wb_RegWrite  = memwb_wb.reg_write;
   assign o_wb_MemtoReg  = memwb_wb.mem_to_reg;
   assign o_wb_dst       = memwb_dst;
   assign o_fwd_a        = fwd_a;
   assign o_fwd_b        = fwd_b;
   assign o_stall_cnt    = stall_cnt;
   assign o_flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench: two controllers (branch in EX with 2-bit counters, branch in MEM with
// 16-bit counters) checked every cycle against an instruction-level model.
module tb_pipe_hazard_ctrl;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2b;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_ADD = 6'h08;
   localparam logic [5:0] OP_NOP = 6'h3f;

   logic       p_clk = 1'b0;
   logic       p_rst, p_i_ce, i_branch_taken;
   logic [5:0] i_opcode;
   logic [4:0] i_rs, i_rt, i_rd;

   logic        pcwe_x, ifwe_x, iffl_x, exrd_x, exas_x, mrd_x, mwr_x, mbr_x, wrw_x, wm2r_x;
   logic [4:0]  wdst_x;
   logic [1:0]  fa_x, fb_x, sc_x, fc_x;
   logic        pcwe_m, ifwe_m, iffl_m, exrd_m, exas_m, mrd_m, mwr_m, mbr_m, wrw_m, wm2r_m;
   logic [4:0]  wdst_m;
   logic [1:0]  fa_m, fb_m;
   logic [15:0] sc_m, fc_m;

   int errors = 0;
   int checks = 0;

   always #5 p_clk = ~p_clk;

   pipe_hazard_ctrl #(.AWIDTH(5), .CNT_WIDTH(2), .BR_IN_EX(1'b1)) dut_x (
      .p_clk(p_clk), .p_rst(p_rst), .p_i_ce(p_i_ce), .i_opcode(i_opcode),
      .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_branch_taken(i_branch_taken),
      .o_pc_we(pcwe_x), .o_ifid_we(ifwe_x), .o_ifid_flush(iffl_x),
      .o_ex_RegDst(exrd_x), .o_ex_ALUSrc(exas_x),
      .o_mem_MemRead(mrd_x), .o_mem_MemWrite(mwr_x), .o_mem_Branch(mbr_x),
      .o_wb_RegWrite(wrw_x), .o_wb_MemtoReg(wm2r_x), .o_wb_dst(wdst_x),
      .o_fwd_a(fa_x), .o_fwd_b(fb_x), .o_stall_cnt(sc_x), .o_flush_cnt(fc_x));

   pipe_hazard_ctrl #(.AWIDTH(5), .CNT_WIDTH(16), .BR_IN_EX(1'b0)) dut_m (
      .p_clk(p_clk), .p_rst(p_rst), .p_i_ce(p_i_ce), .i_opcode(i_opcode),
      .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_branch_taken(i_branch_taken),
      .o_pc_we(pcwe_m), .o_ifid_we(ifwe_m), .o_ifid_flush(iffl_m),
      .o_ex_RegDst(exrd_m), .o_ex_ALUSrc(exas_m),
      .o_mem_MemRead(mrd_m), .o_mem_MemWrite(mwr_m), .o_mem_Branch(mbr_m),
      .o_wb_RegWrite(wrw_m), .o_wb_MemtoReg(wm2r_m), .o_wb_dst(wdst_m),
      .o_fwd_a(fa_m), .o_fwd_b(fb_m), .o_stall_cnt(sc_m), .o_flush_cnt(fc_m));

   // Model: each stage holds the instruction itself; index 0 = dut_x, 1 = dut_m.
   typedef struct packed {
      logic [5:0] op;
      logic [4:0] dst;
      logic [4:0] rs;
      logic [4:0] rt;
   } rec_t;

   localparam rec_t BUB = '{op: 6'h3f, dst: 5'd0, rs: 5'd0, rt: 5'd0};

   rec_t        ex_q[2], mem_q[2], wb_q[2];
   int unsigned stall_n[2], flush_n[2];

   function automatic logic writes_reg(input logic [5:0] op);
      return (op == OP_R) || (op == OP_LW) || (op == OP_ADD);
   endfunction

   function automatic logic m_flush(input int k);
      rec_t r;
      r = (k == 0) ? ex_q[0] : mem_q[1];
      return i_branch_taken && (r.op == OP_BEQ);
   endfunction

   function automatic logic m_loaduse(input int k);
      return (ex_q[k].op == OP_LW) && (ex_q[k].dst != 5'd0) &&
             ((ex_q[k].dst == i_rs) || (ex_q[k].dst == i_rt));
   endfunction

   function automatic logic [1:0] m_fwd(input int k, input logic [4:0] src);
      if (writes_reg(mem_q[k].op) && mem_q[k].dst != 5'd0 && mem_q[k].dst == src) return 2'b10;
      if (writes_reg(wb_q[k].op) && wb_q[k].dst != 5'd0 && wb_q[k].dst == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic int unsigned bump(input int unsigned v, input int k);
      int unsigned mx;
      mx = (k == 0) ? 3 : 65535;
      return (v >= mx) ? mx : v + 1;
   endfunction

   always @(posedge p_clk or negedge p_rst) begin
      if (!p_rst) begin
         for (int k = 0; k < 2; k++) begin
            ex_q[k]    <= BUB;
            mem_q[k]   <= BUB;
            wb_q[k]    <= BUB;
            stall_n[k] <= 0;
            flush_n[k] <= 0;
         end
      end else if (p_i_ce) begin
         for (int k = 0; k < 2; k++) begin
            wb_q[k]  <= mem_q[k];
            mem_q[k] <= (m_flush(k) && k == 1) ? BUB : ex_q[k];
            if (m_flush(k) || m_loaduse(k)) ex_q[k] <= BUB;
            else ex_q[k] <= {i_opcode, (i_opcode == OP_R) ? i_rd : i_rt, i_rs, i_rt};
            if (m_flush(k)) flush_n[k] <= bump(flush_n[k], k);
            else if (m_loaduse(k)) stall_n[k] <= bump(stall_n[k], k);
         end
      end
   end

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   task automatic compare_dut(input int k,
         input logic pcwe, ifwe, iffl, exrd, exas, mrd, mwr, mbr, wrw, wm2r,
         input logic [4:0] wdst, input logic [1:0] fa, fb, input logic [15:0] sc, fc);
      logic fl, st;
      fl = m_flush(k);
      st = m_loaduse(k) && !fl;
      check("pc_we", k, pcwe, p_i_ce && !st);
      check("ifid_we", k, ifwe, p_i_ce && !st);
      check("ifid_flush", k, iffl, p_i_ce && fl);
      check("ex_RegDst", k, exrd, ex_q[k].op == OP_R);
      check("ex_ALUSrc", k, exas, ex_q[k].op inside {OP_LW, OP_SW, OP_ADD});
      check("mem_MemRead", k, mrd, mem_q[k].op == OP_LW);
      check("mem_MemWrite", k, mwr, mem_q[k].op == OP_SW);
      check("mem_Branch", k, mbr, mem_q[k].op == OP_BEQ);
      check("wb_RegWrite", k, wrw, writes_reg(wb_q[k].op));
      check("wb_MemtoReg", k, wm2r, wb_q[k].op == OP_LW);
      check("wb_dst", k, wdst, wb_q[k].dst);
      check("fwd_a", k, fa, m_fwd(k, ex_q[k].rs));
      check("fwd_b", k, fb, m_fwd(k, ex_q[k].rt));
      check("stall_cnt", k, sc, stall_n[k]);
      check("flush_cnt", k, fc, flush_n[k]);
   endtask

   always @(negedge p_clk) begin
      compare_dut(0, pcwe_x, ifwe_x, iffl_x, exrd_x, exas_x, mrd_x, mwr_x, mbr_x,
                  wrw_x, wm2r_x, wdst_x, fa_x, fb_x, {14'd0, sc_x}, {14'd0, fc_x});
      compare_dut(1, pcwe_m, ifwe_m, iffl_m, exrd_m, exas_m, mrd_m, mwr_m, mbr_m,
                  wrw_m, wm2r_m, wdst_m, fa_m, fb_m, sc_m, fc_m);
   end

   task automatic cyc(input logic [5:0] op, input logic [4:0] rs, rt, rd,
                      input logic taken, input logic ce);
      @(posedge p_clk);
      #1;
      i_opcode       = op;
      i_rs           = rs;
      i_rt           = rt;
      i_rd           = rd;
      i_branch_taken = taken;
      p_i_ce         = ce;
   endtask

   task automatic drain(input int n);
      repeat (n) cyc(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
   endtask

   initial begin
      p_rst = 1'b0; p_i_ce = 1'b1; i_branch_taken = 1'b0;
      i_opcode = OP_NOP; i_rs = '0; i_rt = '0; i_rd = '0;
      repeat (2) @(posedge p_clk);
      #2;
      check("rst_pc_we", 0, pcwe_x, 1'b1);
      check("rst_ifid_flush", 1, iffl_m, 1'b0);
      check("rst_stall_cnt", 1, sc_m, 16'd0);
      check("rst_wb_dst", 0, wdst_x, 5'd0);
      @(posedge p_clk); #1; p_rst = 1'b1;

      // lw $5 then add using $5: one stall cycle
      cyc(OP_LW, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1);
      cyc(OP_R, 5'd5, 5'd2, 5'd7, 1'b0, 1'b1); #1;
      check("lu_pc_we", 0, pcwe_x, 1'b0);
      check("lu_ifid_we", 1, ifwe_m, 1'b0);
      cyc(OP_R, 5'd5, 5'd2, 5'd7, 1'b0, 1'b1); #1;
      check("lu_bubble_ex", 0, exrd_x, 1'b0);
      check("lu_mem_read", 0, mrd_x, 1'b1);
      check("lu_stall_cnt", 0, sc_x, 2'd1);
      check("lu_resume", 0, pcwe_x, 1'b1);
      drain(1); #1;
      check("lu_fwd_a_wb", 0, fa_x, 2'b01);
      drain(3);

      // back-to-back dependent adds: MEM forward then WB forward
      cyc(OP_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
      cyc(OP_R, 5'd3, 5'd4, 5'd6, 1'b0, 1'b1);
      cyc(OP_R, 5'd8, 5'd3, 5'd9, 1'b0, 1'b1); #1;
      check("fw_a_mem", 0, fa_x, 2'b10);
      check("fw_no_stall", 0, pcwe_x, 1'b1);
      drain(1); #1;
      check("fw_b_wb", 1, fb_m, 2'b01);
      drain(3);

      // taken beq: dut_x resolves in EX, dut_m one cycle later in MEM
      cyc(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
      cyc(OP_R, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1); #1;
      check("br_flush_ex", 0, iffl_x, 1'b1);
      check("br_wait_mem", 1, iffl_m, 1'b0);
      cyc(OP_R, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1); #1;
      check("br_flush_once", 0, iffl_x, 1'b0);
      check("br_idex_bubble", 0, exrd_x, 1'b0);
      check("br_flush_cnt", 0, fc_x, 2'd1);
      check("br_flush_mem", 1, iffl_m, 1'b1);
      drain(1); #1;
      check("br_exmem_bubble", 1, mbr_m, 1'b0);
      check("br_idex_bubble_m", 1, exrd_m, 1'b0);
      check("br_flush_cnt_m", 1, fc_m, 16'd1);
      check("br_next_ex", 0, exrd_x, 1'b1);
      drain(3);

      // load-use and taken branch together on dut_m: flush only
      cyc(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
      cyc(OP_LW, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1);
      cyc(OP_R, 5'd5, 5'd2, 5'd7, 1'b1, 1'b1); #1;
      check("both_pc_we", 1, pcwe_m, 1'b1);
      check("both_flush", 1, iffl_m, 1'b1);
      check("both_x_stall", 0, pcwe_x, 1'b0);
      drain(1); #1;
      check("both_stall_cnt", 1, sc_m, 16'd1);
      check("both_flush_cnt", 1, fc_m, 16'd2);
      check("both_x_stall_cnt", 0, sc_x, 2'd2);
      drain(3);

      // repeated load-use stalls saturate the 2-bit counter, then freeze
      repeat (6) cyc(OP_LW, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
      cyc(OP_LW, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0); #1;
      check("sat_stall_cnt", 0, sc_x, 2'd3);
      check("sat_stall_cnt_m", 1, sc_m, 16'd4);
      check("ce_pc_we", 0, pcwe_x, 1'b0);
      check("ce_ifid_we", 1, ifwe_m, 1'b0);
      repeat (2) cyc(OP_LW, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
      #1;
      check("ce_hold_cnt", 0, sc_x, 2'd3);
      drain(4);

      // $0 never stalls or forwards
      cyc(OP_LW, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
      cyc(OP_R, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1); #1;
      check("r0_no_stall", 0, pcwe_x, 1'b1);
      drain(1); #1;
      check("r0_fwd_a", 0, fa_x, 2'b00);
      check("r0_fwd_a_m", 1, fa_m, 2'b00);
      drain(2);

      // reset in the middle of a stall
      cyc(OP_LW, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1);
      cyc(OP_R, 5'd5, 5'd2, 5'd7, 1'b0, 1'b1); #1;
      check("mid_stall", 0, pcwe_x, 1'b0);
      #1; p_rst = 1'b0; #1;
      check("mid_rst_pc_we", 0, pcwe_x, 1'b1);
      check("mid_rst_cnt", 0, sc_x, 2'd0);
      check("mid_rst_mem", 1, mrd_m, 1'b0);
      @(posedge p_clk); #1; p_rst = 1'b1;
      cyc(OP_R, 5'd5, 5'd2, 5'd7, 1'b0, 1'b1); #1;
      check("post_rst_pc_we", 0, pcwe_x, 1'b1);
      drain(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
